reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, meaning the first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31, meaning the last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a dump.
REQ-006 abort  in  1  synchronous cancel of a dump in progress.
REQ-007 rd_addr  out  5  register-file read-port address.
REQ-008 rd_data  in  32  register-file read data, combinational from rd_addr.
REQ-009 out_valid  out  1  out_idx, out_data and out_last are valid.
REQ-010 out_ready  in  1  consumer accepts the word.
REQ-011 out_idx  out  5  index of the register being presented.
REQ-012 out_data  out  32  captured register value.
REQ-013 out_last  out  1  presented word is LAST_REG.
REQ-014 busy  out  1  dump in progress.
REQ-015 done  out  1  one-cycle pulse on dump completion.
REQ-016 checksum  out  32  XOR of all words accepted in the current or last dump.

Function
REQ-017 SHALL implement FSM states IDLE, READ, SEND and FIN.
REQ-018 IDLE: start=1 -> READ; idx<=FIRST_REG; checksum<=0.
REQ-019 rd_addr SHALL equal idx in every state.
REQ-020 READ: on the next edge, out_data<=rd_data and out_idx<=idx; -> SEND.
REQ-021 SEND: out_valid=1; out_data and out_idx SHALL be held stable until out_valid&&out_ready.
REQ-022 On out_valid&&out_ready: checksum<=checksum^out_data; if idx==LAST_REG -> FIN, else idx<=idx+1 and -> READ.
REQ-023 FIN: done=1 for exactly one cycle; -> IDLE; checksum SHALL hold until the next start.
REQ-024 out_last SHALL equal out_valid && (out_idx==LAST_REG).
REQ-025 busy SHALL be 1 in READ, SEND and FIN.
REQ-026 Latency: first out_valid SHALL assert 2 cycles after start is sampled; with out_ready held high, one word is delivered every 2 cycles.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with no done pulse and checksum unchanged.
REQ-029 abort takes priority over a simultaneous handshake.
REQ-030 abort together with start in IDLE: start wins.
REQ-031 idx SHALL never wrap past LAST_REG; index 31 is terminal without overflow.
REQ-032 A register write landing between READ and SEND is not reflected; the value sampled in READ is the value delivered.

Reset
REQ-033 rst_n low SHALL immediately force the following outputs, regardless of clk:
- state=IDLE, idx=FIRST_REG
- out_valid=0, out_last=0, out_idx=0, out_data=0
- busy=0, done=0, checksum=0
REQ-034 Reset mid-dump SHALL discard the dump; the first rising edge after rst_n rises SHALL evaluate from IDLE.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state enum (IDLE, READ, SEND, FIN)
- REG_IDX_W=5
- XLEN=32
REQ-036 The block SHALL be a single module with no sub-modules; it connects to the register file's existing read port only.

Verification
REQ-037 Regfile model with x[i]=i*0x11, start, out_ready=1 -> 32 words, idx 0..31, out_last only on idx 31, done pulse once, checksum = XOR of all x[i].
REQ-038 out_ready low for 5 cycles at idx 7 -> out_valid stays 1 with out_data=0x77 stable; resumes at idx 8 after acceptance.
REQ-039 start pulsed again at idx 10 -> ignored; sequence continues uninterrupted.
REQ-040 abort during SEND of idx 4 -> IDLE next cycle, busy=0, no done; a new start restarts at idx 0.
REQ-041 rst_n low during READ of idx 20 -> all outputs 0 asynchronously; after release, idle until start.
REQ-042 FIRST_REG=10, LAST_REG=10 -> exactly one word, idx 10, out_last=1, done; checksum=x[10].

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and widths for the register-file dump engine.
package reg_dump_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump.sv
// Walks register indices FIRST_REG..LAST_REG through the register file's read
// port and streams each captured value out over a valid/ready handshake.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [REG_IDX_W-1:0] rd_addr,
    input  logic [XLEN-1:0]      rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      checksum
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_e               state_reg, state_next;
    logic [REG_IDX_W-1:0] idx_reg, idx_next;
    logic [REG_IDX_W-1:0] out_idx_reg, out_idx_next;
    logic [XLEN-1:0]      out_data_reg, out_data_next;
    logic [XLEN-1:0]      checksum_reg, checksum_next;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        out_idx_next  = out_idx_reg;
        out_data_next = out_data_reg;
        checksum_next = checksum_reg;

        case (state_reg)
            IDLE: begin
                // abort has no meaning here, so a coincident start simply wins
                if (start) begin
                    state_next    = READ;
                    idx_next      = FIRST_IDX;
                    checksum_next = '0;
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    out_data_next = rd_data;
                    out_idx_next  = idx_reg;
                    state_next    = SEND;
                end
            end
            SEND: begin
                // abort outranks the handshake: the word is dropped, checksum untouched
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    checksum_next = checksum_reg ^ out_data_reg;
                    if (idx_reg == LAST_IDX) begin
                        state_next = FIN;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = READ;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= FIRST_IDX;
            out_idx_reg  <= '0;
            out_data_reg <= '0;
            checksum_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            out_idx_reg  <= out_idx_next;
            out_data_reg <= out_data_next;
            checksum_reg <= checksum_next;
        end
    end

    // Every output is a decode of registered state, so the async reset clears them at once.
    assign rd_addr   = idx_reg;
    assign out_valid = (state_reg == SEND);
    assign out_idx   = out_idx_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_valid && (out_idx_reg == LAST_IDX);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);
    assign checksum  = checksum_reg;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: full dump with stall and stray start, abort,
// mid-dump reset, and a single-register configuration.
module tb_reg_dump;
    import reg_dump_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // full-range instance
    logic                 start, abort, out_ready;
    logic [REG_IDX_W-1:0] rd_addr, out_idx;
    logic [XLEN-1:0]      rd_data, out_data, checksum;
    logic                 out_valid, out_last, busy, done;

    // single-register instance
    logic                 start_b, abort_b, out_ready_b;
    logic [REG_IDX_W-1:0] rd_addr_b, out_idx_b;
    logic [XLEN-1:0]      rd_data_b, out_data_b, checksum_b;
    logic                 out_valid_b, out_last_b, busy_b, done_b;

    logic [XLEN-1:0] rf [32];
    assign rd_data   = rf[rd_addr];
    assign rd_data_b = rf[rd_addr_b];

    reg_dump u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .checksum(checksum)
    );

    reg_dump #(.FIRST_REG(10), .LAST_REG(10)) u_dut_one (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_idx(out_idx_b),
        .out_data(out_data_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b), .checksum(checksum_b)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xval(input int i);
        return 32'(i * 17);
    endfunction

    // abort_idx >= 0: abort in SEND of that index; rst_idx >= 0: reset in READ of that index
    task automatic run_dump(input int abort_idx, input int rst_idx, input string name);
        bit          full, ended, restarted, poked;
        int          stop_idx, cyc, first_valid, done_cnt, stall, last_hs;
        logic [31:0] exp_csum, run_csum;
        exp_t        e;

        full      = (abort_idx < 0) && (rst_idx < 0);
        stop_idx  = (abort_idx >= 0) ? abort_idx : ((rst_idx >= 0) ? rst_idx : 32);
        ended     = 1'b0;
        restarted = 1'b0;
        poked     = 1'b0;
        cyc = 0; first_valid = -1; done_cnt = 0; stall = 0; last_hs = -1;
        exp_csum = '0;
        run_csum = '0;
        sb_q.delete();
        for (int i = 0; i < stop_idx; i++) begin
            sb_q.push_back('{idx: 5'(i), data: xval(i), last: (i == 31)});
            exp_csum ^= xval(i);
        end

        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check_val({name, "_lat_read_valid"}, 32'(out_valid), 32'd0);
        check_val({name, "_busy"}, 32'(busy), 32'd1);

        while (!ended && cyc < 400) begin
            abort = 1'b0;
            out_ready = 1'b1;
            start = 1'b0;
            if (done) done_cnt++;
            if (out_valid && first_valid < 0) first_valid = cyc;

            if (full && stall > 0 && stall < 5) begin
                check_val("stall_valid", 32'(out_valid), 32'd1);
                check_val("stall_data", out_data, 32'h77);
                out_ready = 1'b0;
                stall++;
            end else if (full && stall == 0 && out_valid && out_idx == 5'd7) begin
                check_val("stall_data", out_data, 32'h77);
                out_ready = 1'b0;
                stall = 1;
            end
            if (full && out_valid && out_idx == 5'd10 && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (full && out_valid && out_idx == 5'd12 && !poked) begin
                rf[12] = 32'hdeadbeef;
                poked = 1'b1;
            end

            if (abort_idx >= 0 && out_valid && out_idx == 5'(abort_idx)) begin
                abort = 1'b1;
                ended = 1'b1;
            end else if (rst_idx >= 0 && busy && !out_valid && !done && rd_addr == 5'(rst_idx)) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_valid", 32'(out_valid), 32'd0);
                check_val("rst_last", 32'(out_last), 32'd0);
                check_val("rst_idx", 32'(out_idx), 32'd0);
                check_val("rst_data", out_data, 32'd0);
                check_val("rst_busy", 32'(busy), 32'd0);
                check_val("rst_done", 32'(done), 32'd0);
                check_val("rst_csum", checksum, 32'd0);
                check_val("rst_rdaddr", 32'(rd_addr), 32'd0);
                ended = 1'b1;
            end else if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val({name, "_sb_underflow"}, 32'(out_idx), 32'hffffffff);
                end else begin
                    e = sb_q.pop_front();
                    $display("%s word idx=%0d data=%08h last=%0b csum=%08h",
                             name, out_idx, out_data, out_last, checksum);
                    check_val("word_idx", 32'(out_idx), 32'(e.idx));
                    check_val("word_data", out_data, e.data);
                    check_val("word_last", 32'(out_last), 32'(e.last));
                    check_val("run_csum", checksum, run_csum);
                    run_csum ^= e.data;
                    if (full && e.idx == 5'd1) check_val("word_gap", 32'(cyc - last_hs), 32'd2);
                    last_hs = cyc;
                end
            end
            if (full && done) ended = 1'b1;
            @(negedge clk);
            cyc++;
        end

        if (!ended) check_val({name, "_timeout"}, 32'd0, 32'd1);
        check_val({name, "_first_valid_cyc"}, 32'(first_valid), (stop_idx > 0) ? 32'd2 : 32'hffffffff);
        check_val({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);

        if (full) begin
            check_val("full_done_cnt", 32'(done_cnt), 32'd1);
            check_val("full_done_after", 32'(done), 32'd0);
            check_val("full_busy_after", 32'(busy), 32'd0);
            check_val("full_csum", checksum, exp_csum);
            rf[12] = xval(12);
            repeat (3) @(negedge clk);
            check_val("full_csum_hold", checksum, exp_csum);
            check_val("full_done_quiet", 32'(done), 32'd0);
        end else if (abort_idx >= 0) begin
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_valid", 32'(out_valid), 32'd0);
            check_val("abort_done", 32'(done), 32'd0);
            check_val("abort_csum", checksum, exp_csum);
            check_val("abort_done_cnt", 32'(done_cnt), 32'd0);
            @(negedge clk);
            check_val("abort_done_quiet", 32'(done), 32'd0);
        end else begin
            check_val("rst_hold_valid", 32'(out_valid), 32'd0);
            check_val("rst_hold_busy", 32'(busy), 32'd0);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check_val("post_rst_busy", 32'(busy), 32'd0);
            check_val("post_rst_valid", 32'(out_valid), 32'd0);
            check_val("post_rst_done", 32'(done), 32'd0);
            check_val("post_rst_csum", checksum, 32'd0);
        end
    endtask

    task automatic run_single();
        int   done_cnt, seen;
        exp_t e;
        done_cnt = 0;
        seen = 0;
        sb_q.delete();
        sb_q.push_back('{idx: 5'd10, data: xval(10), last: 1'b1});
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done_b) done_cnt++;
            if (out_valid_b && out_ready_b) begin
                seen++;
                if (sb_q.size() == 0) begin
                    check_val("one_sb_underflow", 32'(out_idx_b), 32'hffffffff);
                end else begin
                    e = sb_q.pop_front();
                    $display("one word idx=%0d data=%08h last=%0b", out_idx_b, out_data_b, out_last_b);
                    check_val("one_idx", 32'(out_idx_b), 32'(e.idx));
                    check_val("one_data", out_data_b, e.data);
                    check_val("one_last", 32'(out_last_b), 32'(e.last));
                end
            end
            @(negedge clk);
        end
        check_val("one_words", 32'(seen), 32'd1);
        check_val("one_done_cnt", 32'(done_cnt), 32'd1);
        check_val("one_csum", checksum_b, xval(10));
        check_val("one_busy_after", 32'(busy_b), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = xval(i);
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check_val("reset_valid", 32'(out_valid), 32'd0);
        check_val("reset_last", 32'(out_last), 32'd0);
        check_val("reset_idx", 32'(out_idx), 32'd0);
        check_val("reset_data", out_data, 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_csum", checksum, 32'd0);
        check_val("reset_rdaddr", 32'(rd_addr), 32'd0);
        check_val("reset_rdaddr_one", 32'(rd_addr_b), 32'd10);

        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'd0);

        run_dump(-1, -1, "full");
        run_dump(4, -1, "abort");
        run_dump(-1, 20, "reset");
        run_single();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
